// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response/burst encodings and scheduler FSM states
package axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA
   } state_e;

   // WRAP and the reserved encoding are not supported by this memory model
   function automatic logic burst_illegal(input logic [1:0] burst);
      return (burst == BURST_WRAP) || (burst == 2'b11);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: per-burst beat address sequencer with legality flag
module axi_burst_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_AW     = 10
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  load_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   input  logic                  step_i,
   output logic [MEM_AW-1:0]     waddr_o,
   output logic                  err_o
);

   localparam int LGB = $clog2(DATA_WIDTH / 8);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            size_q, size_d;
   logic [1:0]            burst_q, burst_d;
   logic                  err_q, err_d;

   // load a new burst, otherwise advance INCR bursts by one transfer size per beat
   always_comb begin
      size_d  = load_i ? size_i : size_q;
      burst_d = load_i ? burst_i : burst_q;
      err_d   = load_i ? ((size_i > 3'(LGB)) || burst_illegal(burst_i)) : err_q;
      addr_d  = load_i ? addr_i :
                (step_i && burst_q != BURST_FIXED) ? addr_q + (ADDR_WIDTH'(1) << size_q) : addr_q;
   end

   // burst context registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         addr_q  <= '0;
         size_q  <= '0;
         burst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         size_q  <= size_d;
         burst_q <= burst_d;
         err_q   <= err_d;
      end
   end

   // bits above the memory depth are dropped, so accesses wrap around
   assign waddr_o = addr_q[MEM_AW+LGB-1:LGB];
   assign err_o   = err_q;

endmodule

// File: rtl/axi_slv_mem_sched.sv
// axi_slv_mem_sched: round-robin AW/AR scheduler driving one single-port memory
module axi_slv_mem_sched
   import axi_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int MEM_AW     = 10
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH-1:0]     arid,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH-1:0]     rid,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready,
   output logic                    mem_en,
   output logic                    mem_we,
   output logic [MEM_AW-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_wstrb,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   state_e                state_q, state_d;
   logic                  last_wr_q, last_wr_d;
   logic [ID_WIDTH-1:0]   id_q, id_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  werr_q, werr_d;
   logic                  fresh_q, fresh_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  grant_wr, grant_rd, step, err;

   // contention goes to whichever side was not granted last; nothing is granted under reset
   assign grant_wr = aresetn && state_q == ST_IDLE && awvalid && (!arvalid || !last_wr_q);
   assign grant_rd = aresetn && state_q == ST_IDLE && arvalid && (!awvalid || last_wr_q);

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .MEM_AW     (MEM_AW)
   ) u_addr_gen (
      .aclk    (aclk),
      .aresetn (aresetn),
      .load_i  (grant_wr || grant_rd),
      .addr_i  (grant_wr ? awaddr : araddr),
      .size_i  (grant_wr ? awsize : arsize),
      .burst_i (grant_wr ? awburst : arburst),
      .step_i  (step),
      .waddr_o (mem_addr),
      .err_o   (err)
   );

   // burst sequencing: next state, beat counting and memory strobes
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      id_d      = id_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      werr_d    = werr_q;
      fresh_d   = 1'b0;
      rdata_d   = fresh_q ? mem_rdata : rdata_q;
      step      = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_wr || grant_rd) begin
               id_d      = grant_wr ? awid : arid;
               len_d     = grant_wr ? awlen : arlen;
               cnt_d     = '0;
               werr_d    = 1'b0;
               last_wr_d = grant_wr;
               state_d   = grant_wr ? ST_WR_DATA : ST_RD_REQ;
            end
         end
         ST_WR_DATA: begin
            wready = 1'b1;
            if (wvalid) begin
               mem_en = !err;
               mem_we = !err;
               step   = 1'b1;
               cnt_d  = cnt_q + 8'd1;
               if (wlast || cnt_q == len_q) begin
                  werr_d  = wlast != (cnt_q == len_q);
                  state_d = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            bvalid  = 1'b1;
            state_d = bready ? ST_IDLE : ST_WR_RESP;
         end
         ST_RD_REQ: begin
            mem_en  = 1'b1;
            fresh_d = 1'b1;
            state_d = ST_RD_DATA;
         end
         ST_RD_DATA: begin
            rvalid = 1'b1;
            if (rready) begin
               step    = cnt_q != len_q;
               cnt_d   = cnt_q == len_q ? cnt_q : cnt_q + 8'd1;
               state_d = cnt_q == len_q ? ST_IDLE : ST_RD_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // scheduler state; reset abandons any burst in flight
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         werr_q    <= 1'b0;
         fresh_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         id_q      <= id_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         werr_q    <= werr_d;
         fresh_q   <= fresh_d;
         rdata_q   <= rdata_d;
      end
   end

   // memory data shows up one cycle after the request, so the first RD_DATA cycle
   // forwards it directly while it is captured for the remaining stall cycles
   assign awready   = grant_wr;
   assign arready   = grant_rd;
   assign bid       = id_q;
   assign bresp     = (state_q == ST_WR_RESP && (err || werr_q)) ? RESP_SLVERR : RESP_OKAY;
   assign rid       = id_q;
   assign rresp     = (state_q == ST_RD_DATA && err) ? RESP_SLVERR : RESP_OKAY;
   assign rlast     = state_q == ST_RD_DATA && cnt_q == len_q;
   assign rdata     = err ? '0 : (fresh_q ? mem_rdata : rdata_q);
   assign mem_wdata = wdata;
   assign mem_wstrb = wstrb;

endmodule
